// File: rtl/alu_writeback.sv
// ALU write-back stage: FIFO-buffered ALU results drained into the register-file write port and status register.
// Optional build macro WB_STATUS_STICKY_EN: sticky status flags plus a status_clr input.
module alu_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef WB_STATUS_STICKY_EN
  input  logic                     status_clr,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [AW-1:0]            in_rd,
  input  logic [DW-1:0]            in_result,
  input  logic [3:0]               in_status,
  input  logic                     wr_stall,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  output logic [3:0]               status_q,
  output logic                     illegal_op,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 4 + AW + DW + 4;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake: an entry transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on the pre-edge count, so a pop never frees a slot for the same edge.
  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_en_q, illegal_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic [3:0]      status_d;

  logic            push_w, pop_w;
  logic [EW-1:0]   head_w;
  logic [3:0]      h_op, h_status;
  logic [AW-1:0]   h_rd;
  logic [DW-1:0]   h_result;
  logic            dec_wr, dec_st, dec_ill;

  assign in_ready   = rst_n && (count_q < DEPTH_C);
  assign push_w     = in_valid && in_ready;
  assign pop_w      = (count_q != '0) && !wr_stall;
  assign head_w     = mem_q[rptr_q];
  assign {h_op, h_rd, h_result, h_status} = head_w;

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign illegal_op = illegal_q;
  assign fifo_count = count_q;

  // Op classes: result-only, result+status, status-only (parity), and undefined.
  always_comb begin
    dec_wr  = 1'b0;
    dec_st  = 1'b0;
    dec_ill = 1'b0;
    case (h_op)
      4'b0000, 4'b1010, 4'b1000: dec_wr = 1'b1;
      4'b1011, 4'b1100, 4'b1101,
      4'b1110, 4'b1111, 4'b0111: begin
        dec_wr = 1'b1;
        dec_st = 1'b1;
      end
      4'b1001: dec_st = 1'b1;
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    status_d = status_q;
    if (pop_w && dec_st) begin
`ifdef WB_STATUS_STICKY_EN
      status_d = status_q | h_status;
`else
      status_d = h_status;
`endif
    end
`ifdef WB_STATUS_STICKY_EN
    if (status_clr) status_d = 4'b0000;
`endif
  end

  always_comb begin
    wptr_d  = push_w ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop_w  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    case ({push_w, pop_w})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: occupancy is governed entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wptr_q] <= {in_op, in_rd, in_result, in_status};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      status_q  <= 4'b0000;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      wr_en_q   <= pop_w && dec_wr;
      illegal_q <= pop_w && dec_ill;
      if (pop_w && dec_wr) begin
        wr_addr_q <= h_rd;
        wr_data_q <= h_result;
      end
      status_q  <= status_d;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: table-driven single-entry vectors plus stall, reset and sticky-status sequences.
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       status_clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_op = '0;
  logic [3:0] in_rd = '0;
  logic [7:0] in_result = '0;
  logic [3:0] in_status = '0;
  logic       wr_stall = 1'b0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] status_q;
  logic       illegal_op;
  logic [2:0] fifo_count;

`ifdef WB_STATUS_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  alu_writeback #(.DEPTH(4), .AW(4), .DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef WB_STATUS_STICKY_EN
    .status_clr (status_clr),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_result  (in_result),
    .in_status  (in_status),
    .wr_stall   (wr_stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .status_q   (status_q),
    .illegal_op (illegal_op),
    .fifo_count (fifo_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [3:0] rd;
    logic [7:0] res;
    logic [3:0] st;
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] exp_st;
    logic [3:0] exp_st_sticky;
    logic       ill;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] res,
                       input logic [3:0] st);
    in_valid  = 1'b1;
    in_op     = op;
    in_rd     = rd;
    in_result = res;
    in_status = st;
  endtask

`ifdef WB_STATUS_STICKY_EN
  task automatic send(input logic [3:0] op, input logic [3:0] st, input logic clr);
    @(negedge clk);
    drive(op, 4'h1, 8'h11, st);
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    status_clr = clr;
    @(posedge clk);
    @(negedge clk);
    status_clr = 1'b0;
  endtask
`endif

  initial begin
    int writes;
    int last_cyc;
    logic hs;
    logic [11:0] e;
    logic [3:0] es;

    vecs[0]  = '{4'b1011, 4'h3, 8'h5A, 4'b0010, 1'b1, 4'h3, 8'h5A, 4'b0010, 4'b0010, 1'b0};
    vecs[1]  = '{4'b1001, 4'h0, 8'h00, 4'b1000, 1'b0, 4'h3, 8'h5A, 4'b1000, 4'b1010, 1'b0};
    vecs[2]  = '{4'b0000, 4'h7, 8'hF0, 4'b0001, 1'b1, 4'h7, 8'hF0, 4'b1000, 4'b1010, 1'b0};
    vecs[3]  = '{4'b0011, 4'h2, 8'h11, 4'b1111, 1'b0, 4'h7, 8'hF0, 4'b1000, 4'b1010, 1'b1};
    vecs[4]  = '{4'b1010, 4'hF, 8'hFF, 4'b0100, 1'b1, 4'hF, 8'hFF, 4'b1000, 4'b1010, 1'b0};
    vecs[5]  = '{4'b0111, 4'h1, 8'h01, 4'b0001, 1'b1, 4'h1, 8'h01, 4'b0001, 4'b1011, 1'b0};
    vecs[6]  = '{4'b0001, 4'h4, 8'h44, 4'b0110, 1'b0, 4'h1, 8'h01, 4'b0001, 4'b1011, 1'b1};
    vecs[7]  = '{4'b0110, 4'h5, 8'h55, 4'b0010, 1'b0, 4'h1, 8'h01, 4'b0001, 4'b1011, 1'b1};
    vecs[8]  = '{4'b1000, 4'h9, 8'h99, 4'b1111, 1'b1, 4'h9, 8'h99, 4'b0001, 4'b1011, 1'b0};
    vecs[9]  = '{4'b1111, 4'h0, 8'h00, 4'b0000, 1'b1, 4'h0, 8'h00, 4'b0000, 4'b1011, 1'b0};
    vecs[10] = '{4'b1100, 4'h6, 8'hA5, 4'b1100, 1'b1, 4'h6, 8'hA5, 4'b1100, 4'b1111, 1'b0};
    vecs[11] = '{4'b1101, 4'hE, 8'h3C, 4'b0011, 1'b1, 4'hE, 8'h3C, 4'b0011, 4'b1111, 1'b0};
    vecs[12] = '{4'b1110, 4'hB, 8'hC3, 4'b0101, 1'b1, 4'hB, 8'hC3, 4'b0101, 4'b1111, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_count", fifo_count, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_status", status_q, 0);
    check("rst_illegal", illegal_op, 0);
    rst_n = 1'b1;
    #1 check("ready_after_rst", in_ready, 1);

    // Table: one entry into an empty FIFO, pop one edge later, outputs two edges after push
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].rd, vecs[i].res, vecs[i].st);
      check($sformatf("v%0d_ready", i), in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_count1", i), fifo_count, 1);
      check($sformatf("v%0d_no_bypass", i), wr_en, 0);
      @(posedge clk);
      @(negedge clk);
      es = STICKY ? vecs[i].exp_st_sticky : vecs[i].exp_st;
      check($sformatf("v%0d_wr_en", i), wr_en, vecs[i].we);
      check($sformatf("v%0d_addr", i), wr_addr, vecs[i].addr);
      check($sformatf("v%0d_data", i), wr_data, vecs[i].data);
      check($sformatf("v%0d_status", i), status_q, es);
      check($sformatf("v%0d_illegal", i), illegal_op, vecs[i].ill);
      check($sformatf("v%0d_count0", i), fifo_count, 0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_wr_en_drop", i), wr_en, 0);
      check($sformatf("v%0d_illegal_drop", i), illegal_op, 0);
    end

    // Stall fill: 4 accepted, 5th held until a slot frees, then in-order drain
    @(negedge clk);
    wr_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(4'b0000, 4'(i + 8), 8'(8'h10 + i), 4'b0000);
      exp_q.push_back({4'(i + 8), 8'(8'h10 + i)});
      check($sformatf("stall_ready%0d", i), in_ready, (i < 4) ? 1 : 0);
      @(posedge clk);
      @(negedge clk);
    end
    check("full_count", fifo_count, 4);
    check("full_ready", in_ready, 0);
    check("full_no_write", wr_en, 0);
    wr_stall = 1'b0;
    writes = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      hs = in_valid && in_ready;
      @(posedge clk);
      @(negedge clk);
      if (hs) in_valid = 1'b0;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("drain_extra_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("drain_addr%0d", writes), wr_addr, e[11:8]);
          check($sformatf("drain_data%0d", writes), wr_data, e[7:0]);
          check($sformatf("drain_cycle%0d", writes), cyc, last_cyc + 1);
        end
        last_cyc = cyc;
        writes++;
      end
    end
    check("drain_writes", writes, 5);
    check("drain_left", exp_q.size(), 0);
    check("drain_count", fifo_count, 0);

    // Reset mid-stream discards queued entries
    @(negedge clk);
    wr_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'b1011, 4'(i + 1), 8'(8'hE0 + i), 4'b1111);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre_rst_count", fifo_count, 3);
    rst_n = 1'b0;
    wr_stall = 1'b0;
    #1 check("ready_in_rst", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_status", status_q, 0);
    check("mid_rst_addr", wr_addr, 0);
    check("mid_rst_data", wr_data, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("post_rst_wr_en%0d", i), wr_en, 0);
      check($sformatf("post_rst_status%0d", i), status_q, 0);
    end

`ifdef WB_STATUS_STICKY_EN
    // Sticky flags accumulate; clear wins over a same-edge update
    send(4'b1011, 4'b0001, 1'b0);
    check("sticky_first", status_q, 4'b0001);
    send(4'b1100, 4'b0100, 1'b0);
    check("sticky_or", status_q, 4'b0101);
    send(4'b1011, 4'b0010, 1'b1);
    check("sticky_clr_priority", status_q, 4'b0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
